// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target and master state encodings, bus bit constants.
package i2c_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StWrByte,
      StWrAck,
      StRdByte,
      StRdAck
   } slave_state_e;

   typedef enum logic [2:0] {
      MstIdle,
      MstStart,
      MstAddr,
      MstData,
      MstAck,
      MstStop
   } master_state_e;

   localparam logic I2C_RW_READ = 1'b1;
   localparam logic I2C_ACK     = 1'b0;
   localparam logic I2C_NACK    = 1'b1;

   // Header byte is {addr[6:0], rw}
   function automatic logic addr_match(input logic [7:0] hdr, input logic [6:0] addr);
      return hdr[7:1] == addr;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and produces one-clk bus event pulses.
module i2c_bus_sync #(
   parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_hist_q;
   logic                   sda_hist_q;
   logic                   scl_rise_q;
   logic                   scl_fall_q;
   logic                   start_q;
   logic                   stop_q;
   logic                   scl_cur;
   logic                   sda_cur;

   assign scl_cur = scl_sync_q[SYNC_STAGES-1];
   assign sda_cur = sda_sync_q[SYNC_STAGES-1];

   // Synchroniser chains, history flops and registered edge events; idle bus is high
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
         scl_hist_q <= scl_cur;
         sda_hist_q <= sda_cur;
         scl_rise_q <= scl_cur & ~scl_hist_q;
         scl_fall_q <= ~scl_cur & scl_hist_q;
         start_q    <= scl_cur & scl_hist_q & sda_hist_q & ~sda_cur;
         stop_q     <= scl_cur & scl_hist_q & ~sda_hist_q & sda_cur;
      end
   end

   assign sda_s     = sda_cur;
   assign scl_rise  = scl_rise_q;
   assign scl_fall  = scl_fall_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address; receives write bytes, sends read bytes.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] data_in,
   output logic       tx_req,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       busy
);

   slave_state_e state_q;
   logic [2:0]   bit_cnt_q;
   logic [7:0]   rx_shift_q;
   logic [7:0]   tx_shift_q;
   logic [7:0]   data_out_q;
   logic         rw_q;
   logic         got_q;  // 8th bit (or master ACK) sampled, act on next scl_fall
   logic         sda_drive_q;
   logic         tx_req_q;
   logic         data_valid_q;
   logic         busy_q;

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_bus_sync (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda      (sda),
      .sda_s    (sda_s),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start_det(start_det),
      .stop_det (stop_det)
   );

   // Target FSM: START/STOP override everything, then scl edges advance the byte protocol
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         bit_cnt_q    <= 3'd0;
         rx_shift_q   <= 8'h00;
         tx_shift_q   <= 8'h00;
         data_out_q   <= 8'h00;
         rw_q         <= 1'b0;
         got_q        <= 1'b0;
         sda_drive_q  <= 1'b0;
         tx_req_q     <= 1'b0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         tx_req_q     <= 1'b0;
         data_valid_q <= 1'b0;
         if (start_det) begin
            state_q     <= StAddr;
            bit_cnt_q   <= 3'd7;
            got_q       <= 1'b0;
            sda_drive_q <= 1'b0;
            busy_q      <= 1'b0;
         end else if (stop_det) begin
            state_q     <= StIdle;
            got_q       <= 1'b0;
            sda_drive_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               StAddr, StWrByte: begin
                  if (scl_rise) begin
                     rx_shift_q <= {rx_shift_q[6:0], sda_s};
                     if (bit_cnt_q == 3'd0) got_q <= 1'b1;
                     else                   bit_cnt_q <= bit_cnt_q - 3'd1;
                  end else if (scl_fall && got_q) begin
                     got_q <= 1'b0;
                     if (state_q == StAddr) begin
                        if (addr_match(rx_shift_q, SLAVE_ADDR)) begin
                           rw_q        <= rx_shift_q[0];
                           sda_drive_q <= 1'b1;
                           busy_q      <= 1'b1;
                           state_q     <= StAddrAck;
                        end else begin
                           state_q <= StIdle;
                        end
                     end else begin
                        data_out_q   <= rx_shift_q;
                        data_valid_q <= 1'b1;
                        sda_drive_q  <= 1'b1;
                        state_q      <= StWrAck;
                     end
                  end
               end
               StAddrAck: begin
                  if (scl_fall) begin
                     sda_drive_q <= 1'b0;
                     bit_cnt_q   <= 3'd7;
                     if (rw_q == I2C_RW_READ) begin
                        tx_req_q <= 1'b1;
                        state_q  <= StRdByte;
                     end else begin
                        state_q <= StWrByte;
                     end
                  end
               end
               StWrAck: begin
                  if (scl_fall) begin
                     sda_drive_q <= 1'b0;
                     bit_cnt_q   <= 3'd7;
                     state_q     <= StWrByte;
                  end
               end
               StRdByte: begin
                  // data_in is valid on the clk where tx_req is high
                  if (tx_req_q) begin
                     tx_shift_q  <= data_in;
                     sda_drive_q <= ~data_in[7];
                  end else if (scl_rise) begin
                     if (bit_cnt_q == 3'd0) got_q <= 1'b1;
                     else                   bit_cnt_q <= bit_cnt_q - 3'd1;
                  end else if (scl_fall) begin
                     if (got_q) begin
                        got_q       <= 1'b0;
                        sda_drive_q <= 1'b0;
                        state_q     <= StRdAck;
                     end else begin
                        sda_drive_q <= ~tx_shift_q[bit_cnt_q];
                     end
                  end
               end
               StRdAck: begin
                  if (scl_rise) begin
                     if (sda_s == I2C_NACK) state_q <= StIdle;
                     else                   got_q <= 1'b1;
                  end else if (scl_fall && got_q) begin
                     got_q     <= 1'b0;
                     tx_req_q  <= 1'b1;
                     bit_cnt_q <= 3'd7;
                     state_q   <= StRdByte;
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign sda        = sda_drive_q ? 1'b0 : 1'bz;
   assign tx_req     = tx_req_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bus-level master tasks, table of directed transfers,
// randomized transfers against a transaction-level model, reset corner cases.
`timescale 1ns/1ps
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam logic [6:0] ADDR = 7'h50;

   logic       clk    = 1'b0;
   logic       reset  = 1'b1;
   logic       scl    = 1'b1;
   logic       m_low  = 1'b0;
   logic [7:0] data_in = 8'h00;
   wire        sda;
   logic       tx_req, data_valid, busy;
   logic [7:0] data_out;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave #(
      .SLAVE_ADDR (ADDR),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .data_in   (data_in),
      .tx_req    (tx_req),
      .data_out  (data_out),
      .data_valid(data_valid),
      .busy      (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int dv_cnt = 0, tx_cnt = 0, tx_hi_cnt = 0;
   logic [7:0] dv_log [64];
   logic [7:0] rd_mem [64];

   // Client side: log received bytes, serve read bytes on tx_req
   always @(negedge clk) begin
      if (data_valid) begin
         dv_log[dv_cnt % 64] = data_out;
         dv_cnt++;
      end
      if (tx_req) begin
         data_in = rd_mem[tx_cnt % 64];
         tx_cnt++;
         if (scl) tx_hi_cnt++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Works for both a first START and a repeated START (scl low on entry)
   task automatic bus_start();
      m_low = 1'b0; tick(6);
      scl   = 1'b1; tick(4);
      m_low = 1'b1; tick(4);
      scl   = 1'b0;
   endtask

   task automatic bus_stop();
      tick(2);
      m_low = 1'b1; tick(4);
      scl   = 1'b1; tick(4);
      m_low = 1'b0; tick(4);
   endtask

   // One bit: drive b during scl low (1 = release), sample bus mid-high
   task automatic bus_bit(input logic b, output logic r);
      tick(2);
      m_low = ~b; tick(6);
      scl   = 1'b1; tick(3);
      r     = sda; tick(3);
      scl   = 1'b0;
   endtask

   task automatic xfer(input logic [6:0] addr, input logic rw, input int n,
                       input logic [31:0] wdata, input logic do_stop,
                       output logic aack, output logic [3:0] wack,
                       output logic [31:0] rdata, output logic busy_mid,
                       output logic busy_end);
      logic r;
      wack  = 4'hF;
      rdata = 32'h0;
      busy_end = 1'b0;
      bus_start();
      for (int i = 6; i >= 0; i--) bus_bit(addr[i], r);
      bus_bit(rw, r);
      bus_bit(1'b1, aack);
      busy_mid = busy;
      if (aack == I2C_ACK) begin
         for (int k = 0; k < n; k++) begin
            if (rw == I2C_RW_READ) begin
               for (int i = 7; i >= 0; i--) begin
                  bus_bit(1'b1, r);
                  rdata[8*k+i] = r;
               end
               bus_bit((k == n - 1) ? I2C_NACK : I2C_ACK, r);
            end else begin
               for (int i = 7; i >= 0; i--) bus_bit(wdata[8*k+i], r);
               bus_bit(1'b1, wack[k]);
            end
         end
      end
      if (do_stop) begin
         bus_stop();
         tick(4);
         busy_end = busy;
      end
   endtask

   task automatic run_case(input logic [6:0] addr, input logic rw, input int n,
                           input logic [31:0] data, input logic do_stop,
                           input logic exp_aack, input int exp_dv, input int exp_tx,
                           input logic exp_busy);
      int dv0, tx0, hi0;
      logic aack, bm, be;
      logic [3:0] wack;
      logic [31:0] rdata;
      dv0 = dv_cnt; tx0 = tx_cnt; hi0 = tx_hi_cnt;
      for (int k = 0; k < n; k++) rd_mem[(tx_cnt + k) % 64] = data[8*k +: 8];
      xfer(addr, rw, n, data, do_stop, aack, wack, rdata, bm, be);
      chk("addr_ack", aack, exp_aack);
      chk("busy_mid", bm, exp_busy);
      chk("dv_count", dv_cnt - dv0, exp_dv);
      chk("tx_req_count", tx_cnt - tx0, exp_tx);
      chk("tx_req_while_scl_high", tx_hi_cnt - hi0, 0);
      if (do_stop) chk("busy_after_stop", be, 1'b0);
      for (int k = 0; k < exp_dv; k++) begin
         chk("wr_byte", dv_log[(dv0 + k) % 64], data[8*k +: 8]);
         chk("wr_data_ack", wack[k], I2C_ACK);
      end
      if (exp_tx > 0)
         for (int k = 0; k < n; k++) chk("rd_byte", rdata[8*k +: 8], data[8*k +: 8]);
   endtask

   // Transaction-level reference: what a single-address target must do
   function automatic void model(input logic [6:0] a, input logic rw, input int n,
                                 output logic aack, output int dv, output int tx,
                                 output logic bm);
      logic hit;
      hit  = (a == ADDR);
      aack = hit ? I2C_ACK : I2C_NACK;
      dv   = (hit && rw != I2C_RW_READ) ? n : 0;
      tx   = (hit && rw == I2C_RW_READ) ? n : 0;
      bm   = hit;
   endfunction

   typedef struct {
      logic [6:0]  addr;
      logic        rw;
      int          n;
      logic [31:0] data;
      logic        stop;
      logic        exp_aack;
      int          exp_dv;
      int          exp_tx;
      logic        exp_busy;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic r;
      logic [6:0] a;
      logic [6:0] ra;
      logic rrw, m_aack, m_bm;
      int rn, m_dv, m_tx, dv0;
      logic [31:0] rdat;

      vecs[0] = '{addr: ADDR,  rw: 1'b0, n: 1, data: 32'h0000_00A5, stop: 1'b1,
                  exp_aack: 1'b0, exp_dv: 1, exp_tx: 0, exp_busy: 1'b1};
      vecs[1] = '{addr: ADDR,  rw: 1'b1, n: 1, data: 32'h0000_003C, stop: 1'b1,
                  exp_aack: 1'b0, exp_dv: 0, exp_tx: 1, exp_busy: 1'b1};
      vecs[2] = '{addr: 7'h51, rw: 1'b0, n: 1, data: 32'h0000_0055, stop: 1'b1,
                  exp_aack: 1'b1, exp_dv: 0, exp_tx: 0, exp_busy: 1'b0};
      vecs[3] = '{addr: ADDR,  rw: 1'b1, n: 2, data: 32'h0000_8001, stop: 1'b1,
                  exp_aack: 1'b0, exp_dv: 0, exp_tx: 2, exp_busy: 1'b1};

      // Reset state
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_req", tx_req, 1'b0);
      chk("rst_data_valid", data_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_sda", sda, 1'b1);
      tick(1);
      reset = 1'b0;
      tick(4);

      foreach (vecs[i])
         run_case(vecs[i].addr, vecs[i].rw, vecs[i].n, vecs[i].data, vecs[i].stop,
                  vecs[i].exp_aack, vecs[i].exp_dv, vecs[i].exp_tx, vecs[i].exp_busy);

      // Write then repeated START into a read
      run_case(ADDR, 1'b0, 1, 32'h11, 1'b0, 1'b0, 1, 0, 1'b1);
      run_case(ADDR, 1'b1, 1, 32'h7E, 1'b1, 1'b0, 0, 1, 1'b1);

      // Reset while the target is pulling the address ACK low
      a = ADDR;
      bus_start();
      for (int i = 6; i >= 0; i--) bus_bit(a[i], r);
      bus_bit(1'b0, r);
      m_low = 1'b0;
      tick(8);
      chk("ack_driven_before_reset", sda, I2C_ACK);
      chk("busy_before_reset", busy, 1'b1);
      reset = 1'b1;
      tick(1);
      chk("sda_released_by_reset", sda, 1'b1);
      chk("busy_cleared_by_reset", busy, 1'b0);
      reset = 1'b0;
      tick(4);
      scl = 1'b1; tick(6);
      scl = 1'b0;
      bus_stop();

      // Reset during bit 4 of a write: no byte delivered, next write works
      dv0 = dv_cnt;
      bus_start();
      for (int i = 6; i >= 0; i--) bus_bit(a[i], r);
      bus_bit(1'b0, r);
      bus_bit(1'b1, r);
      chk("addr_ack_pre_abort", r, I2C_ACK);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
      tick(2);
      m_low = 1'b0; tick(6);
      scl = 1'b1; tick(2);
      reset = 1'b1;
      tick(1);
      chk("sda_released_bit4", sda, 1'b1);
      reset = 1'b0;
      tick(2);
      scl = 1'b0;
      for (int i = 0; i < 5; i++) bus_bit(1'b1, r);
      bus_stop();
      tick(4);
      chk("no_dv_after_abort", dv_cnt - dv0, 0);
      run_case(ADDR, 1'b0, 1, 32'hFF, 1'b1, 1'b0, 1, 0, 1'b1);

      // Randomized transfers against the transaction model
      for (int t = 0; t < 30; t++) begin
         case ($urandom_range(0, 3))
            0, 1:    ra = ADDR;
            2:       ra = 7'h51;
            default: ra = 7'($urandom_range(0, 127));
         endcase
         rrw  = 1'($urandom_range(0, 1));
         rn   = int'($urandom_range(1, 4));
         rdat = $urandom;
         model(ra, rrw, rn, m_aack, m_dv, m_tx, m_bm);
         run_case(ra, rrw, rn, rdat, 1'b1, m_aack, m_dv, m_tx, m_bm);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
